// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared servo constants, duty-cycle type and sequencer states
package servo_pkg;

    localparam int DC_W      = 32;
    localparam int MIN_DC    = 50000;
    localparam int MAX_DC    = 100000;
    localparam int STEP      = 2780;
    localparam int CENTER_DC = (MIN_DC + MAX_DC) / 2;
    localparam int SLEW      = 1000;
    localparam int DEPTH     = 8;
    localparam int DWELL     = 25;

    typedef logic [DC_W-1:0] dc_t;

    typedef enum logic [1:0] {
        MANUAL     = 2'd0,
        PLAY_MOVE  = 2'd1,
        PLAY_DWELL = 2'd2
    } state_t;

endpackage

// File: rtl/servo_wp_mem.sv
// rtl/servo_wp_mem.sv - waypoint register file, synchronous write, asynchronous read
module servo_wp_mem
    import servo_pkg::*;
#(
    parameter int DEPTH_P = servo_pkg::DEPTH,
    parameter int AW      = $clog2(DEPTH_P)
) (
    input  logic          slow_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  dc_t           wdata,
    input  logic [AW-1:0] raddr,
    output dc_t           rdata
);

    dc_t r_mem [DEPTH_P];

    // Storage is deliberately unreset; slots beyond wp_count are never read.
    always_ff @(posedge slow_clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/servo_waypoint_seq.sv
// rtl/servo_waypoint_seq.sv - manual/teach/playback position source for the servo PWM stage
module servo_waypoint_seq
    import servo_pkg::*;
#(
    parameter int MIN_DC = servo_pkg::MIN_DC,
    parameter int MAX_DC = servo_pkg::MAX_DC,
    parameter int STEP   = servo_pkg::STEP,
    parameter int SLEW   = servo_pkg::SLEW,
    parameter int DEPTH  = servo_pkg::DEPTH,
    parameter int DWELL  = servo_pkg::DWELL
) (
    input  logic                     slow_clk,
    input  logic                     rst,
    input  logic                     inc_pulse,
    input  logic                     dec_pulse,
    input  logic                     store_pulse,
    input  logic                     play_pulse,
    input  logic                     clear_pulse,
    output dc_t                      dc_out,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   wp_count,
    output logic                     full
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int DWW = $clog2(DWELL + 1);
    localparam int SW  = DC_W + 1;

    localparam dc_t           C_MIN    = dc_t'(MIN_DC);
    localparam dc_t           C_MAX    = dc_t'(MAX_DC);
    localparam dc_t           C_STEP   = dc_t'(STEP);
    localparam dc_t           C_CENTER = dc_t'((MIN_DC + MAX_DC) / 2);
    localparam dc_t           C_SLEW   = dc_t'(SLEW);
    localparam logic [SW-1:0] C_SLEW_W = SW'(SLEW);

    state_t          r_state, w_state_nx;
    dc_t             r_dc, w_dc_nx;
    logic [CW-1:0]   r_wp_count, w_wp_nx;
    logic [AW-1:0]   r_idx, w_idx_nx;
    logic [DWW-1:0]  r_dwell, w_dwell_nx;
    logic            r_busy;
    logic            w_we;
    logic            w_full;
    dc_t             w_target;
    logic [SW-1:0]   w_diff;
    logic [SW-1:0]   w_abs;

    servo_wp_mem #(
        .DEPTH_P (DEPTH),
        .AW      (AW)
    ) u_mem (
        .slow_clk (slow_clk),
        .we       (w_we),
        .waddr    (r_wp_count[AW-1:0]),
        .wdata    (r_dc),
        .raddr    (r_idx),
        .rdata    (w_target)
    );

    assign w_full = (r_wp_count == CW'(DEPTH));

    // One extra bit keeps the target-minus-position difference free of wraparound.
    assign w_diff = {1'b0, w_target} - {1'b0, r_dc};
    assign w_abs  = w_diff[SW-1] ? (~w_diff + 1'b1) : w_diff;

    always_comb begin
        w_state_nx = r_state;
        w_dc_nx    = r_dc;
        w_wp_nx    = r_wp_count;
        w_idx_nx   = r_idx;
        w_dwell_nx = r_dwell;
        w_we       = 1'b0;
        case (r_state)
            MANUAL: begin
                if (clear_pulse) begin
                    w_wp_nx = '0;
                end else if (play_pulse) begin
                    if (r_wp_count != '0) begin
                        w_idx_nx   = '0;
                        w_state_nx = PLAY_MOVE;
                    end
                end else if (store_pulse) begin
                    if (!w_full) begin
                        w_we    = 1'b1;
                        w_wp_nx = r_wp_count + 1'b1;
                    end
                end else if (inc_pulse) begin
                    if (r_dc + C_STEP <= C_MAX) begin
                        w_dc_nx = r_dc + C_STEP;
                    end
                end else if (dec_pulse) begin
                    if (r_dc >= C_MIN + C_STEP) begin
                        w_dc_nx = r_dc - C_STEP;
                    end
                end
            end
            PLAY_MOVE, PLAY_DWELL: begin
                if (clear_pulse) begin
                    w_state_nx = MANUAL;
                    w_wp_nx    = '0;
                end else if (play_pulse) begin
                    w_state_nx = MANUAL;
                end else if (r_state == PLAY_MOVE) begin
                    if (w_abs <= C_SLEW_W) begin
                        w_dc_nx    = w_target;
                        w_dwell_nx = '0;
                        w_state_nx = PLAY_DWELL;
                    end else if (w_diff[SW-1]) begin
                        w_dc_nx = r_dc - C_SLEW;
                    end else begin
                        w_dc_nx = r_dc + C_SLEW;
                    end
                end else begin
                    w_dwell_nx = r_dwell + 1'b1;
                    if (r_dwell == DWW'(DWELL - 1)) begin
                        w_idx_nx   = ((CW'(r_idx) + 1'b1) == r_wp_count) ? '0 : r_idx + 1'b1;
                        w_state_nx = PLAY_MOVE;
                    end
                end
            end
            default: begin
                w_state_nx = MANUAL;
            end
        endcase
    end

    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            r_state    <= MANUAL;
            r_dc       <= C_CENTER;
            r_wp_count <= '0;
            r_idx      <= '0;
            r_dwell    <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_dc       <= w_dc_nx;
            r_wp_count <= w_wp_nx;
            r_idx      <= w_idx_nx;
            r_dwell    <= w_dwell_nx;
            r_busy     <= (w_state_nx != MANUAL);
        end
    end

    assign dc_out   = r_dc;
    assign busy     = r_busy;
    assign wp_count = r_wp_count;
    assign full     = w_full;

endmodule

// File: tb/tb_servo_waypoint_seq.sv
// tb/tb_servo_waypoint_seq.sv - scoreboard bench for the servo waypoint sequencer
module tb_servo_waypoint_seq;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_CLR  = 5'b10000;
    localparam logic [4:0] P_PLAY = 5'b01000;
    localparam logic [4:0] P_STO  = 5'b00100;
    localparam logic [4:0] P_INC  = 5'b00010;
    localparam logic [4:0] P_DEC  = 5'b00001;

    typedef struct packed {
        logic [31:0] dc;
        logic [3:0]  wp;
        logic        busy;
        logic        full;
    } obs_t;

    typedef struct {
        logic [4:0] p;
        int         n;
    } stim_t;

    logic        slow_clk = 1'b0;
    logic        rst = 1'b0;
    logic        inc_pulse = 1'b0;
    logic        dec_pulse = 1'b0;
    logic        store_pulse = 1'b0;
    logic        play_pulse = 1'b0;
    logic        clear_pulse = 1'b0;
    logic [31:0] dc_out;
    logic        busy;
    logic [3:0]  wp_count;
    logic        full;
    obs_t        w_obs;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    int m_dc, m_wp, m_idx, m_dwell, m_phase;
    int m_mem [8];

    servo_waypoint_seq dut (
        .slow_clk    (slow_clk),
        .rst         (rst),
        .inc_pulse   (inc_pulse),
        .dec_pulse   (dec_pulse),
        .store_pulse (store_pulse),
        .play_pulse  (play_pulse),
        .clear_pulse (clear_pulse),
        .dc_out      (dc_out),
        .busy        (busy),
        .wp_count    (wp_count),
        .full        (full)
    );

    always #5 slow_clk = ~slow_clk;

    assign w_obs = {dc_out, wp_count, busy, full};

    function automatic obs_t exp_now();
        obs_t e;
        e.dc   = 32'(m_dc);
        e.wp   = 4'(m_wp);
        e.busy = (m_phase != 0);
        e.full = (m_wp == 8);
        return e;
    endfunction

    // Reference behaviour for one tick with pulse vector {clear, play, store, inc, dec}.
    task automatic model_tick(input logic [4:0] p);
        int d;
        if (m_phase == 0) begin
            if (p[4]) m_wp = 0;
            else if (p[3]) begin
                if (m_wp != 0) begin
                    m_idx = 0;
                    m_phase = 1;
                end
            end else if (p[2]) begin
                if (m_wp < 8) begin
                    m_mem[m_wp] = m_dc;
                    m_wp++;
                end
            end else if (p[1]) begin
                if (m_dc + 2780 <= 100000) m_dc += 2780;
            end else if (p[0]) begin
                if (m_dc - 2780 >= 50000) m_dc -= 2780;
            end
        end else if (p[4]) begin
            m_phase = 0;
            m_wp = 0;
        end else if (p[3]) begin
            m_phase = 0;
        end else if (m_phase == 1) begin
            d = m_mem[m_idx] - m_dc;
            if (d <= 1000 && d >= -1000) begin
                m_dc = m_mem[m_idx];
                m_dwell = 0;
                m_phase = 2;
            end else begin
                m_dc += (d > 0) ? 1000 : -1000;
            end
        end else begin
            if (m_dwell == 24) begin
                m_idx = (m_idx + 1) % m_wp;
                m_phase = 1;
            end else begin
                m_dwell++;
            end
        end
    endtask

    task automatic drive(input logic [4:0] p);
        @(negedge slow_clk);
        {clear_pulse, play_pulse, store_pulse, inc_pulse, dec_pulse} = p;
        @(posedge slow_clk);
        #1;
        {clear_pulse, play_pulse, store_pulse, inc_pulse, dec_pulse} = P_NONE;
    endtask

    task automatic test_reset();
        obs_t e;
        rst = 1'b0;
        m_dc = 75000; m_wp = 0; m_idx = 0; m_dwell = 0; m_phase = 0;
        sb.push_back(exp_now());
        repeat (2) @(posedge slow_clk);
        #1;
        e = sb.pop_front();
        n_checks++;
        if (w_obs !== e) begin
            n_fail++;
            $display("FAIL reset: dc=%0d wp=%0d busy=%b full=%b, expected dc=%0d wp=%0d busy=%b full=%b",
                     dc_out, wp_count, busy, full, e.dc, e.wp, e.busy, e.full);
        end
        @(negedge slow_clk);
        rst = 1'b1;
    endtask

    task automatic test_inc_dec();
        obs_t e;
        for (int i = 0; i < 28; i++) begin
            logic [4:0] p;
            p = (i < 10) ? P_INC : P_DEC;
            model_tick(p);
            sb.push_back(exp_now());
            drive(p);
            e = sb.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL inc_dec[%0d]: dc=%0d wp=%0d busy=%b full=%b, expected dc=%0d wp=%0d busy=%b full=%b",
                         i, dc_out, wp_count, busy, full, e.dc, e.wp, e.busy, e.full);
            end
        end
        n_checks++;
        if (dc_out !== 32'd52760) begin
            n_fail++;
            $display("FAIL dec_floor: dc=%0d, expected 52760", dc_out);
        end
    endtask

    task automatic test_store_full();
        obs_t e;
        for (int i = 0; i < 18; i++) begin
            logic [4:0] p;
            p = (i == 17) ? P_CLR : ((i % 2 == 0) || i == 16) ? P_STO : P_INC;
            if (i == 17) begin
                for (int k = 0; k < 8; k++) begin
                    n_checks++;
                    if (dut.u_mem.r_mem[k] !== 32'(m_mem[k])) begin
                        n_fail++;
                        $display("FAIL store_mem[%0d]: got %0d, expected %0d", k, dut.u_mem.r_mem[k], m_mem[k]);
                    end
                end
            end
            model_tick(p);
            sb.push_back(exp_now());
            drive(p);
            e = sb.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL store_full[%0d]: dc=%0d wp=%0d busy=%b full=%b, expected dc=%0d wp=%0d busy=%b full=%b",
                         i, dc_out, wp_count, busy, full, e.dc, e.wp, e.busy, e.full);
            end
        end
    endtask

    task automatic test_play_empty();
        obs_t e;
        for (int i = 0; i < 2; i++) begin
            logic [4:0] p;
            p = (i == 0) ? P_PLAY : P_NONE;
            model_tick(p);
            sb.push_back(exp_now());
            drive(p);
            e = sb.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL play_empty[%0d]: dc=%0d wp=%0d busy=%b full=%b, expected dc=%0d wp=%0d busy=%b full=%b",
                         i, dc_out, wp_count, busy, full, e.dc, e.wp, e.busy, e.full);
            end
        end
    endtask

    task automatic test_playback();
        obs_t  e;
        stim_t tbl [9];
        int    t;
        tbl = '{'{P_DEC, 8}, '{P_STO, 1}, '{P_INC, 16}, '{P_STO, 1}, '{P_DEC, 8},
                '{P_PLAY, 1}, '{P_NONE, 13}, '{P_PLAY, 1}, '{P_PLAY, 1}};
        t = 0;
        foreach (tbl[r]) begin
            for (int j = 0; j < tbl[r].n; j++) begin
                model_tick(tbl[r].p);
                sb.push_back(exp_now());
                drive(tbl[r].p);
                e = sb.pop_front();
                n_checks++;
                if (w_obs !== e) begin
                    n_fail++;
                    $display("FAIL playback_setup[%0d]: dc=%0d wp=%0d busy=%b full=%b, expected dc=%0d wp=%0d busy=%b full=%b",
                             t, dc_out, wp_count, busy, full, e.dc, e.wp, e.busy, e.full);
                end
                t++;
            end
            if (r == 7) begin
                n_checks++;
                if (dc_out !== 32'd62000 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stop_mid_slew: dc=%0d busy=%b, expected dc=62000 busy=0", dc_out, busy);
                end
            end
        end
        for (int i = 0; i < 131; i++) begin
            logic [4:0] p;
            p = (i == 30 || i == 80) ? P_INC : (i == 130) ? P_PLAY : P_NONE;
            model_tick(p);
            sb.push_back(exp_now());
            drive(p);
            e = sb.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL playback[%0d]: dc=%0d wp=%0d busy=%b full=%b, expected dc=%0d wp=%0d busy=%b full=%b",
                         i, dc_out, wp_count, busy, full, e.dc, e.wp, e.busy, e.full);
            end
        end
    endtask

    task automatic test_priority();
        obs_t       e;
        logic [4:0] tbl [6];
        tbl = '{P_CLR | P_STO, P_STO | P_INC, P_INC | P_DEC,
                P_PLAY | P_INC | P_STO, P_STO | P_INC, P_CLR | P_PLAY};
        foreach (tbl[i]) begin
            model_tick(tbl[i]);
            sb.push_back(exp_now());
            drive(tbl[i]);
            e = sb.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL priority[%0d]: dc=%0d wp=%0d busy=%b full=%b, expected dc=%0d wp=%0d busy=%b full=%b",
                         i, dc_out, wp_count, busy, full, e.dc, e.wp, e.busy, e.full);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t       e;
        logic [4:0] tbl [6];
        tbl = '{P_DEC, P_STO, P_PLAY, P_NONE, P_NONE, P_NONE};
        foreach (tbl[i]) begin
            model_tick(tbl[i]);
            sb.push_back(exp_now());
            drive(tbl[i]);
            e = sb.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL dwell_entry[%0d]: dc=%0d wp=%0d busy=%b full=%b, expected dc=%0d wp=%0d busy=%b full=%b",
                         i, dc_out, wp_count, busy, full, e.dc, e.wp, e.busy, e.full);
            end
        end
        #2;
        rst = 1'b0;
        m_dc = 75000; m_wp = 0; m_idx = 0; m_dwell = 0; m_phase = 0;
        sb.push_back(exp_now());
        #1;
        e = sb.pop_front();
        n_checks++;
        if (w_obs !== e) begin
            n_fail++;
            $display("FAIL async_reset: dc=%0d wp=%0d busy=%b full=%b, expected dc=%0d wp=%0d busy=%b full=%b",
                     dc_out, wp_count, busy, full, e.dc, e.wp, e.busy, e.full);
        end
        @(negedge slow_clk);
        rst = 1'b1;
        model_tick(P_INC);
        sb.push_back(exp_now());
        drive(P_INC);
        e = sb.pop_front();
        n_checks++;
        if (w_obs !== e) begin
            n_fail++;
            $display("FAIL after_reset: dc=%0d wp=%0d busy=%b full=%b, expected dc=%0d wp=%0d busy=%b full=%b",
                     dc_out, wp_count, busy, full, e.dc, e.wp, e.busy, e.full);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_inc_dec();
        test_store_full();
        test_play_empty();
        test_playback();
        test_priority();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
